// File: rtl/rle_index_tracker_pkg.sv
// Shared types and constants for the run-length index tracker and its seek-side helpers.
package rle_index_tracker_pkg;

   localparam int unsigned DEF_SAMPLE_W = 16;
   localparam int unsigned DEF_INDEX_W  = 60;

   // Escape/continuation word: all-ones at the stream word width.
   localparam logic [DEF_SAMPLE_W-1:0] ESCAPE_WORD = '1;

   typedef enum logic [1:0] {
      ST_HEAD  = 2'b00,
      ST_LIT   = 2'b01,
      ST_COUNT = 2'b10
   } state_t;

   // The unused encoding 2'b11 falls back to HEAD.
   function automatic state_t decode_state(input logic [1:0] raw);
      case (raw)
         2'b01:   return ST_LIT;
         2'b10:   return ST_COUNT;
         default: return ST_HEAD;
      endcase
   endfunction

endpackage

// File: rtl/rle_index_tracker_if.sv
// Stream-in / status-out bundle between the capture reader and the index tracker.
// Optional statistics signals are present only with RLE_INDEX_TRACKER_STATS_EN.
interface rle_index_tracker_if #(
   parameter int unsigned SAMPLE_W = rle_index_tracker_pkg::DEF_SAMPLE_W,
   parameter int unsigned INDEX_W  = rle_index_tracker_pkg::DEF_INDEX_W
) ();

   logic [SAMPLE_W-1:0] sample;
   logic                sample_strobe;
   logic [INDEX_W-1:0]  target;
   logic [INDEX_W-1:0]  index;
   logic [SAMPLE_W-1:0] value;
   logic                in_run;
   logic                run_done;
   logic [INDEX_W-1:0]  run_len;
   logic                hit;
   logic                overflow;
`ifdef RLE_INDEX_TRACKER_STATS_EN
   logic [31:0]         run_count;
   logic [INDEX_W-1:0]  max_run;
`endif

   modport master (
      output sample, sample_strobe, target,
      input  index, value, in_run, run_done, run_len, hit, overflow
`ifdef RLE_INDEX_TRACKER_STATS_EN
      , input run_count, max_run
`endif
   );

   modport slave (
      input  sample, sample_strobe, target,
      output index, value, in_run, run_done, run_len, hit, overflow
`ifdef RLE_INDEX_TRACKER_STATS_EN
      , output run_count, max_run
`endif
   );

endinterface

// File: rtl/rle_index_target_cmp.sv
// Index adder with target-crossing detect and sticky wrap flag; shared with the seek logic.
module rle_index_target_cmp #(
   parameter int unsigned INDEX_W = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [INDEX_W-1:0] old_index,
   input  logic [INDEX_W-1:0] inc,
   input  logic [INDEX_W-1:0] target,
   output logic [INDEX_W-1:0] new_index_c,
   output logic               hit,
   output logic               overflow
);

   localparam int unsigned SUM_W = INDEX_W + 1;

   logic [SUM_W-1:0] sum_c;
   logic [SUM_W-1:0] target_x_c;
   logic             hit_c;

   // Compare on the carry-extended sum so a wrapping add still sees targets above old_index.
   assign sum_c       = SUM_W'(old_index) + SUM_W'(inc);
   assign target_x_c  = SUM_W'(target);
   assign hit_c       = (SUM_W'(old_index) < target_x_c) && (target_x_c <= sum_c);
   assign new_index_c = sum_c[INDEX_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         hit      <= 1'b0;
         overflow <= 1'b0;
      end else if (en) begin
         hit      <= hit_c;
         overflow <= overflow | sum_c[INDEX_W];
      end else begin
         hit      <= 1'b0;
      end
   end

endmodule

// File: rtl/rle_index_tracker.sv
// Run-length stream decoder tracking absolute sample index, run events and target hits.
// Define RLE_INDEX_TRACKER_STATS_EN to add run_count / max_run statistics.
module rle_index_tracker #(
   parameter int unsigned SAMPLE_W = rle_index_tracker_pkg::DEF_SAMPLE_W,
   parameter int unsigned INDEX_W  = rle_index_tracker_pkg::DEF_INDEX_W
) (
   input logic                clk,
   input logic                rst,
   rle_index_tracker_if.slave bus
);

   import rle_index_tracker_pkg::*;

   localparam int unsigned          ACC_W  = INDEX_W + 1;
   localparam logic [SAMPLE_W-1:0] ESCAPE = '1;

   state_t              state_q, state_n;
   logic [SAMPLE_W-1:0] last_q;
   logic [SAMPLE_W-1:0] value_q, value_n;
   logic [INDEX_W-1:0]  index_q;
   logic [INDEX_W-1:0]  acc_q, acc_n;
   logic [INDEX_W-1:0]  run_len_q, run_len_n;
   logic                run_done_q, run_done_n;
   logic                in_run_q;
   logic                hit_q;
   logic                overflow_q;
   logic [INDEX_W-1:0]  inc_c;
   logic [INDEX_W-1:0]  new_index_c;
   logic [ACC_W-1:0]    acc_sum_c;

   assign acc_sum_c = ACC_W'(acc_q) + ACC_W'(bus.sample);

   // Next-state and next-output decode for the current word.
   always_comb begin
      state_n    = state_q;
      value_n    = value_q;
      acc_n      = acc_q;
      run_len_n  = run_len_q;
      run_done_n = 1'b0;
      inc_c      = '0;
      case (decode_state(state_q))
         ST_LIT: begin
            inc_c   = INDEX_W'(1);
            value_n = bus.sample;
            acc_n   = INDEX_W'(2);
            state_n = (bus.sample == last_q) ? ST_COUNT : ST_LIT;
         end
         ST_COUNT: begin
            inc_c = INDEX_W'(bus.sample);
            acc_n = acc_sum_c[INDEX_W] ? '1 : acc_sum_c[INDEX_W-1:0];
            if (bus.sample != ESCAPE) begin
               state_n    = ST_HEAD;
               run_done_n = 1'b1;
               run_len_n  = acc_n;
            end
         end
         default: begin
            inc_c   = INDEX_W'(1);
            value_n = bus.sample;
            state_n = ST_LIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_HEAD;
         last_q     <= '0;
         value_q    <= '0;
         index_q    <= '0;
         acc_q      <= '0;
         run_len_q  <= '0;
         run_done_q <= 1'b0;
         in_run_q   <= 1'b0;
      end else if (bus.sample_strobe) begin
         state_q    <= state_n;
         last_q     <= bus.sample;
         value_q    <= value_n;
         index_q    <= new_index_c;
         acc_q      <= acc_n;
         run_len_q  <= run_len_n;
         run_done_q <= run_done_n;
         in_run_q   <= (state_n == ST_COUNT);
      end else begin
         run_done_q <= 1'b0;
      end
   end

   rle_index_target_cmp #(.INDEX_W(INDEX_W)) u_cmp (
      .clk         (clk),
      .rst         (rst),
      .en          (bus.sample_strobe),
      .old_index   (index_q),
      .inc         (inc_c),
      .target      (bus.target),
      .new_index_c (new_index_c),
      .hit         (hit_q),
      .overflow    (overflow_q)
   );

   assign bus.index    = index_q;
   assign bus.value    = value_q;
   assign bus.in_run   = in_run_q;
   assign bus.run_done = run_done_q;
   assign bus.run_len  = run_len_q;
   assign bus.hit      = hit_q;
   assign bus.overflow = overflow_q;

`ifdef RLE_INDEX_TRACKER_STATS_EN
   logic [31:0]        run_count_q;
   logic [INDEX_W-1:0] max_run_q;

   // Statistics follow run_done: saturating run counter and longest run.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_count_q <= '0;
         max_run_q   <= '0;
      end else if (bus.sample_strobe && run_done_n) begin
         if (run_count_q != '1) run_count_q <= run_count_q + 32'd1;
         if (acc_n > max_run_q) max_run_q <= acc_n;
      end
   end

   assign bus.run_count = run_count_q;
   assign bus.max_run   = max_run_q;
`endif

endmodule

// File: tb/tb_rle_index_tracker.sv
// Directed bench for rle_index_tracker: a 60-bit-index instance and a 17-bit one for wrap cases.
module tb_rle_index_tracker;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   rle_index_tracker_if #(.SAMPLE_W(16), .INDEX_W(60)) bus ();
   rle_index_tracker_if #(.SAMPLE_W(16), .INDEX_W(17)) bus17 ();

   rle_index_tracker #(.SAMPLE_W(16), .INDEX_W(60)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   rle_index_tracker #(.SAMPLE_W(16), .INDEX_W(17)) dut17 (
      .clk (clk),
      .rst (rst),
      .bus (bus17)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [15:0] w);
      bus.sample        = w;
      bus.sample_strobe = 1'b1;
      @(posedge clk);
      #1;
      bus.sample_strobe = 1'b0;
   endtask

   task automatic step17(input logic [15:0] w);
      bus17.sample        = w;
      bus17.sample_strobe = 1'b1;
      @(posedge clk);
      #1;
      bus17.sample_strobe = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask

   initial begin
      rst                 = 1'b1;
      bus.sample          = '0;
      bus.sample_strobe   = 1'b0;
      bus.target          = '0;
      bus17.sample        = '0;
      bus17.sample_strobe = 1'b0;
      bus17.target        = '0;
      idle();
      idle();
      chk("rst_index",    64'(bus.index), 0);
      chk("rst_value",    64'(bus.value), 0);
      chk("rst_in_run",   64'(bus.in_run), 0);
      chk("rst_run_done", 64'(bus.run_done), 0);
      chk("rst_run_len",  64'(bus.run_len), 0);
      chk("rst_hit",      64'(bus.hit), 0);
      chk("rst_overflow", 64'(bus.overflow), 0);
      chk("rst_index17",  64'(bus17.index), 0);
      rst = 1'b0;

      // Basic run: 5, 7, 7, count 3
      step(16'h0005); chk("t1_idx1", 64'(bus.index), 1); chk("t1_val1", 64'(bus.value), 5);
      chk("t1_inrun1", 64'(bus.in_run), 0);
      step(16'h0007); chk("t1_idx2", 64'(bus.index), 2); chk("t1_val2", 64'(bus.value), 7);
      step(16'h0007); chk("t1_idx3", 64'(bus.index), 3); chk("t1_inrun3", 64'(bus.in_run), 1);
      chk("t1_done3", 64'(bus.run_done), 0);
      step(16'h0003); chk("t1_idx4", 64'(bus.index), 6); chk("t1_done4", 64'(bus.run_done), 1);
      chk("t1_len4", 64'(bus.run_len), 5); chk("t1_val4", 64'(bus.value), 7);
      chk("t1_inrun4", 64'(bus.in_run), 0);

      // Gap without strobe: registers hold, pulse drops
      idle();
      chk("gap_done", 64'(bus.run_done), 0); chk("gap_idx", 64'(bus.index), 6);
      chk("gap_val", 64'(bus.value), 7); chk("gap_len", 64'(bus.run_len), 5);

      // HEAD ignores a repeat of the previous run value
      step(16'h0007); chk("t3_idx1", 64'(bus.index), 7); chk("t3_inrun1", 64'(bus.in_run), 0);
      step(16'h0009); chk("t3_idx2", 64'(bus.index), 8); chk("t3_inrun2", 64'(bus.in_run), 0);
      chk("t3_val2", 64'(bus.value), 9);

      // 17-bit index: preload to 0x1FFFE, then wrap
      step17(16'h0005); chk("w_idx1", 64'(bus17.index), 1);
      step17(16'h0005); chk("w_idx2", 64'(bus17.index), 2); chk("w_inrun2", 64'(bus17.in_run), 1);
      step17(16'hFFFF); chk("w_idx3", 64'(bus17.index), 65537); chk("w_inrun3", 64'(bus17.in_run), 1);
      step17(16'hFFFD); chk("w_idx4", 64'(bus17.index), 64'h1FFFE);
      chk("w_done4", 64'(bus17.run_done), 1); chk("w_len4", 64'(bus17.run_len), 64'h1FFFE);
      chk("w_ovf4", 64'(bus17.overflow), 0);
      bus17.target = 17'h1FFFF;
      step17(16'h0001); chk("w_idx5", 64'(bus17.index), 64'h1FFFF); chk("w_hit5", 64'(bus17.hit), 1);
      chk("w_ovf5", 64'(bus17.overflow), 0);
      step17(16'h0003); chk("w_idx6", 64'(bus17.index), 0); chk("w_ovf6", 64'(bus17.overflow), 1);
      chk("w_hit6", 64'(bus17.hit), 0);
      step17(16'h0003); chk("w_idx7", 64'(bus17.index), 1); chk("w_inrun7", 64'(bus17.in_run), 1);
      step17(16'h0004); chk("w_idx8", 64'(bus17.index), 5); chk("w_done8", 64'(bus17.run_done), 1);
      chk("w_len8", 64'(bus17.run_len), 6); chk("w_ovf8", 64'(bus17.overflow), 1);

      // Reset mid-COUNT with a coincident strobe
      step(16'h0009); chk("mr_idx", 64'(bus.index), 9); chk("mr_inrun", 64'(bus.in_run), 1);
      rst                 = 1'b1;
      bus.sample          = 16'h0003;
      bus.sample_strobe   = 1'b1;
      bus17.sample        = 16'h0003;
      bus17.sample_strobe = 1'b1;
      idle();
      rst                 = 1'b0;
      bus.sample_strobe   = 1'b0;
      bus17.sample_strobe = 1'b0;
      chk("mr_rst_idx", 64'(bus.index), 0); chk("mr_rst_inrun", 64'(bus.in_run), 0);
      chk("mr_rst_done", 64'(bus.run_done), 0); chk("mr_rst_len", 64'(bus.run_len), 0);
      chk("mr_rst_idx17", 64'(bus17.index), 0); chk("mr_rst_ovf17", 64'(bus17.overflow), 0);
      step(16'h0040); chk("mr_head_idx", 64'(bus.index), 1); chk("mr_head_inrun", 64'(bus.in_run), 0);

      // Continuation through an escape word
      do_reset();
      step(16'h0001); chk("t2_idx1", 64'(bus.index), 1);
      step(16'h0001); chk("t2_idx2", 64'(bus.index), 2); chk("t2_inrun2", 64'(bus.in_run), 1);
      step(16'hFFFF); chk("t2_idx3", 64'(bus.index), 65537); chk("t2_inrun3", 64'(bus.in_run), 1);
      chk("t2_done3", 64'(bus.run_done), 0);
      step(16'h0002); chk("t2_idx4", 64'(bus.index), 65539); chk("t2_done4", 64'(bus.run_done), 1);
      chk("t2_len4", 64'(bus.run_len), 65539); chk("t2_inrun4", 64'(bus.in_run), 0);

      // Hit on a count word crossing target=4
      do_reset();
      bus.target = 60'd4;
      step(16'h000A); chk("h_hit1", 64'(bus.hit), 0);
      step(16'h000B); chk("h_hit2", 64'(bus.hit), 0);
      step(16'h000B); chk("h_idx3", 64'(bus.index), 3); chk("h_hit3", 64'(bus.hit), 0);
      step(16'h0010); chk("h_idx4", 64'(bus.index), 19); chk("h_hit4", 64'(bus.hit), 1);
      chk("h_len4", 64'(bus.run_len), 18);
      idle(); chk("h_gap_hit", 64'(bus.hit), 0);
      bus.target = 60'd0;
      step(16'h0005); chk("h_t0_idx", 64'(bus.index), 20); chk("h_t0_hit", 64'(bus.hit), 0);

      // target equal to old index does not re-hit; zero count ends a run
      do_reset();
      bus.target = 60'd3;
      step(16'h0021); chk("e_hit1", 64'(bus.hit), 0);
      step(16'h0022); chk("e_hit2", 64'(bus.hit), 0);
      step(16'h0023); chk("e_idx3", 64'(bus.index), 3); chk("e_hit3", 64'(bus.hit), 1);
      step(16'h0024); chk("e_idx4", 64'(bus.index), 4); chk("e_hit4", 64'(bus.hit), 0);
      step(16'h0024); chk("e_idx5", 64'(bus.index), 5); chk("e_inrun5", 64'(bus.in_run), 1);
      step(16'h0000); chk("e_idx6", 64'(bus.index), 5); chk("e_done6", 64'(bus.run_done), 1);
      chk("e_len6", 64'(bus.run_len), 2); chk("e_inrun6", 64'(bus.in_run), 0);

      // 17-bit: hit detected across a wrapping count; run_len saturation
      do_reset();
      bus17.target = 17'h1FFFF;
      step17(16'h0005);
      step17(16'h0005);
      step17(16'hFFFF);
      step17(16'hFFFB); chk("x_idx4", 64'(bus17.index), 64'h1FFFC); chk("x_hit4", 64'(bus17.hit), 0);
      chk("x_len4", 64'(bus17.run_len), 64'h1FFFC);
      step17(16'h0001); chk("x_idx5", 64'(bus17.index), 64'h1FFFD);
      step17(16'h0001); chk("x_idx6", 64'(bus17.index), 64'h1FFFE); chk("x_inrun6", 64'(bus17.in_run), 1);
      step17(16'h0004); chk("x_idx7", 64'(bus17.index), 2); chk("x_ovf7", 64'(bus17.overflow), 1);
      chk("x_hit7", 64'(bus17.hit), 1); chk("x_len7", 64'(bus17.run_len), 6);
      step17(16'h0005); chk("s_idx1", 64'(bus17.index), 3);
      step17(16'h0005); chk("s_idx2", 64'(bus17.index), 4);
      step17(16'hFFFF); chk("s_idx3", 64'(bus17.index), 65539); chk("s_hit3", 64'(bus17.hit), 0);
      step17(16'hFFFF); chk("s_idx4", 64'(bus17.index), 2); chk("s_hit4", 64'(bus17.hit), 1);
      step17(16'h0000); chk("s_done5", 64'(bus17.run_done), 1);
      chk("s_len5", 64'(bus17.run_len), 64'h1FFFF); chk("s_idx5", 64'(bus17.index), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
